fft_out_reorder: RTL

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer turning a 16-lane, bit-reversed 512-bin FFT frame into natural order.
// Define FFT_REORDER_ERR_EN to add the frame_err protocol-error pulse output.
module fft_out_reorder #(
  parameter int DW      = 13,
  parameter int N_BEATS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic signed [DW-1:0] din_re [16],
  input  logic signed [DW-1:0] din_im [16],
  output logic                 dout_valid,
  output logic                 dout_sof,
  output logic                 dout_eof,
  output logic signed [DW-1:0] dout_re [16],
  output logic signed [DW-1:0] dout_im [16]
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int         LANES     = 16;
  localparam int         BINS      = 512;
  localparam logic [4:0] LAST_BEAT = 5'(N_BEATS - 1);

  typedef enum logic { W_IDLE, W_FILL  } w_state_t;
  typedef enum logic { R_IDLE, R_DRAIN } r_state_t;

  function automatic logic [8:0] bitrev9(input logic [8:0] x);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = x[8-i];
    return r;
  endfunction

  w_state_t   w_state, w_state_nx;
  r_state_t   r_state, r_state_nx;
  logic [4:0] w_beat, w_beat_nx, wr_beat;
  logic [4:0] rd_beat, rd_beat_nx, issue_beat;
  logic       wr_bank, rd_bank, rd_bank_nx;
  logic [1:0] full, set_mask, clr_mask;
  logic       we, frame_done, issue, drain_done;

  logic signed [DW-1:0] mem_re [2][BINS];
  logic signed [DW-1:0] mem_im [2][BINS];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = w_state;
    w_beat_nx  = w_beat;
    wr_beat    = w_beat;
    we         = 1'b0;
    frame_done = 1'b0;
    if (din_valid) begin
      unique case (w_state)
        W_IDLE: if (din_sof && !full[wr_bank]) begin
          we      = 1'b1;
          wr_beat = '0;
        end
        W_FILL: begin
          we = 1'b1;
          if (din_sof) wr_beat = '0;
        end
      endcase
      if (we) begin
        if (wr_beat == LAST_BEAT) begin
          frame_done = 1'b1;
          w_state_nx = W_IDLE;
          w_beat_nx  = '0;
        end else begin
          w_state_nx = W_FILL;
          w_beat_nx  = wr_beat + 5'd1;
        end
      end
    end
  end

  // A bank is picked up the cycle after it fills, so a held frame chains straight after an eof.
  always_comb begin
    r_state_nx = r_state;
    rd_beat_nx = rd_beat;
    rd_bank_nx = rd_bank;
    issue_beat = rd_beat;
    issue      = 1'b0;
    drain_done = 1'b0;
    unique case (r_state)
      R_IDLE: if (full[rd_bank]) begin
        issue      = 1'b1;
        issue_beat = '0;
        r_state_nx = R_DRAIN;
        rd_beat_nx = 5'd1;
      end
      R_DRAIN: begin
        issue = 1'b1;
        if (rd_beat == LAST_BEAT) begin
          drain_done = 1'b1;
          r_state_nx = R_IDLE;
          rd_beat_nx = '0;
          rd_bank_nx = ~rd_bank;
        end else begin
          rd_beat_nx = rd_beat + 5'd1;
        end
      end
    endcase
  end

  assign set_mask = frame_done ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = drain_done ? (2'b01 << rd_bank) : 2'b00;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_beat  <= '0;
      rd_beat <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
      w_beat  <= w_beat_nx;
      rd_beat <= rd_beat_nx;
      wr_bank <= frame_done ? ~wr_bank : wr_bank;
      rd_bank <= rd_bank_nx;
      full    <= (full | set_mask) & ~clr_mask;
    end
  end

  // NOTE: the sample banks carry no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[wr_bank][bitrev9({wr_beat, 4'(l)})] <= din_re[l];
        mem_im[wr_bank][bitrev9({wr_beat, 4'(l)})] <= din_im[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
    end else begin
      dout_valid <= issue;
      dout_sof   <= issue && (issue_beat == '0);
      dout_eof   <= issue && (issue_beat == LAST_BEAT);
      if (issue) begin
        for (int l = 0; l < LANES; l++) begin
          dout_re[l] <= mem_re[rd_bank][{issue_beat, 4'(l)}];
          dout_im[l] <= mem_im[rd_bank][{issue_beat, 4'(l)}];
        end
      end
    end
  end

`ifdef FFT_REORDER_ERR_EN
  // Stray beats of a dropped frame are part of that one error, not new ones.
  logic dropping;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropping  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (din_valid && din_sof && w_state == W_IDLE) dropping <= full[wr_bank];
      frame_err <= din_valid && (
                     (w_state == W_FILL && din_sof) ||
                     (w_state == W_IDLE && din_sof && full[wr_bank]) ||
                     (w_state == W_IDLE && !din_sof && !dropping));
    end
  end
`endif

endmodule
